// File: rtl/axi_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axi_wr_arbiter
//  Description : Round-robin arbiter sharing one AXI4 write channel set
//                (AW/W/B) among NUM_MASTERS requesters. One transaction is
//                in flight at a time; the grant is held from AW acceptance
//                through the wlast beat to the B handshake. All channel
//                paths are combinational muxes off the registered grant.
//                Optional watchdog enabled by macro AXI_WR_ARB_TIMEOUT_EN
//                (adds timeout_err output and TIMEOUT_CYCLES parameter).
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_wr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int ID_WIDTH    = 8,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
`ifdef AXI_WR_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                              aclk,
    input  logic                              areset,
    // per-master AW
    input  logic [NUM_MASTERS-1:0]            s_awvalid,
    output logic [NUM_MASTERS-1:0]            s_awready,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_awaddr,
    input  logic [NUM_MASTERS*ID_WIDTH-1:0]   s_awid,
    input  logic [NUM_MASTERS*8-1:0]          s_awlen,
    input  logic [NUM_MASTERS*3-1:0]          s_awsize,
    input  logic [NUM_MASTERS*2-1:0]          s_awburst,
    // per-master W
    input  logic [NUM_MASTERS-1:0]            s_wvalid,
    output logic [NUM_MASTERS-1:0]            s_wready,
    input  logic [NUM_MASTERS-1:0]            s_wlast,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] s_wdata,
    input  logic [NUM_MASTERS*STRB_WIDTH-1:0] s_wstrb,
    // per-master B (id/resp broadcast)
    output logic [NUM_MASTERS-1:0]            s_bvalid,
    input  logic [NUM_MASTERS-1:0]            s_bready,
    output logic [ID_WIDTH-1:0]               s_bid,
    output logic [1:0]                        s_bresp,
    // downstream AW
    output logic                              m_awvalid,
    input  logic                              m_awready,
    output logic [ADDR_WIDTH-1:0]             m_awaddr,
    output logic [ID_WIDTH-1:0]               m_awid,
    output logic [7:0]                        m_awlen,
    output logic [2:0]                        m_awsize,
    output logic [1:0]                        m_awburst,
    // downstream W
    output logic                              m_wvalid,
    input  logic                              m_wready,
    output logic [DATA_WIDTH-1:0]             m_wdata,
    output logic [STRB_WIDTH-1:0]             m_wstrb,
    output logic                              m_wlast,
    // downstream B
    input  logic                              m_bvalid,
    output logic                              m_bready,
    input  logic [ID_WIDTH-1:0]               m_bid,
    input  logic [1:0]                        m_bresp,
    // status
    output logic                              busy,
`ifdef AXI_WR_ARB_TIMEOUT_EN
    output logic                              timeout_err,
`endif
    output logic [IDX_W-1:0]                  grant_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    // Master 0 wins the first arbitration after reset.
    localparam logic [IDX_W-1:0] c_LAST_GRANT_RST = IDX_W'(NUM_MASTERS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;

    logic             w_pick_found;
    logic [IDX_W-1:0] w_pick_idx;
    logic [IDX_W-1:0] w_cand;

    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_b_hs;

    // Round-robin search starting just above the last completed grant.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        w_cand       = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            w_cand = IDX_W'((32'(last_grant_q) + 32'(k)) % 32'(NUM_MASTERS));
            if (!w_pick_found && s_awvalid[w_cand]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_cand;
            end
        end
    end

    // Handshake qualifiers for the granted master in the active phase.
    always_comb begin
        w_aw_hs = (state_q == ADDR) && s_awvalid[grant_q] && m_awready;
        w_w_hs  = (state_q == DATA) && s_wvalid[grant_q]  && m_wready;
        w_b_hs  = (state_q == RESP) && m_bvalid && s_bready[grant_q];
    end

    // Next-state logic and channel muxing; everything idles at zero.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;

        s_awready = '0;
        s_wready  = '0;
        s_bvalid  = '0;
        s_bid     = '0;
        s_bresp   = 2'b00;
        m_awvalid = 1'b0;
        m_awaddr  = '0;
        m_awid    = '0;
        m_awlen   = 8'd0;
        m_awsize  = 3'd0;
        m_awburst = 2'd0;
        m_wvalid  = 1'b0;
        m_wdata   = '0;
        m_wstrb   = '0;
        m_wlast   = 1'b0;
        m_bready  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (w_pick_found) begin
                    grant_d = w_pick_idx;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                m_awvalid          = s_awvalid[grant_q];
                m_awaddr           = s_awaddr[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
                m_awid             = s_awid[grant_q*ID_WIDTH +: ID_WIDTH];
                m_awlen            = s_awlen[grant_q*8 +: 8];
                m_awsize           = s_awsize[grant_q*3 +: 3];
                m_awburst          = s_awburst[grant_q*2 +: 2];
                s_awready[grant_q] = m_awready;
                if (w_aw_hs) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                m_wvalid          = s_wvalid[grant_q];
                m_wdata           = s_wdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
                m_wstrb           = s_wstrb[grant_q*STRB_WIDTH +: STRB_WIDTH];
                m_wlast           = s_wlast[grant_q];
                s_wready[grant_q] = m_wready;
                // wlast alone ends the burst; beat count is not tracked.
                if (w_w_hs && s_wlast[grant_q]) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                s_bvalid[grant_q] = m_bvalid;
                m_bready          = s_bready[grant_q];
                s_bid             = m_bid;
                s_bresp           = m_bresp;
                if (w_b_hs) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and grant registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= c_LAST_GRANT_RST;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign grant_idx = grant_q;

`ifdef AXI_WR_ARB_TIMEOUT_EN
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        timeout_err_q, timeout_err_d;

    // Stall counter: cleared by any handshake or while idle; error is sticky.
    always_comb begin
        to_cnt_d      = to_cnt_q;
        timeout_err_d = timeout_err_q;
        if ((state_q == IDLE) || w_aw_hs || w_w_hs || w_b_hs) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != 16'hFFFF) begin
            to_cnt_d = to_cnt_q + 16'd1;
        end
        if (to_cnt_d == 16'(TIMEOUT_CYCLES)) begin
            timeout_err_d = 1'b1;
        end
    end

    // Watchdog registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_wr_arbiter
//  Description : Self-checking bench for axi_wr_arbiter: table of complete
//                single-master transactions plus hand-written sequences for
//                round-robin, backpressure, early W, mid-burst reset and
//                (when AXI_WR_ARB_TIMEOUT_EN is defined) the watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_wr_arbiter;

    localparam int NM = 4;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int SW = 4;
    localparam int IW = 8;

    logic              aclk, areset;
    logic [NM-1:0]     s_awvalid, s_awready;
    logic [NM*AW-1:0]  s_awaddr;
    logic [NM*IW-1:0]  s_awid;
    logic [NM*8-1:0]   s_awlen;
    logic [NM*3-1:0]   s_awsize;
    logic [NM*2-1:0]   s_awburst;
    logic [NM-1:0]     s_wvalid, s_wready, s_wlast;
    logic [NM*DW-1:0]  s_wdata;
    logic [NM*SW-1:0]  s_wstrb;
    logic [NM-1:0]     s_bvalid, s_bready;
    logic [IW-1:0]     s_bid;
    logic [1:0]        s_bresp;
    logic              m_awvalid, m_awready;
    logic [AW-1:0]     m_awaddr;
    logic [IW-1:0]     m_awid;
    logic [7:0]        m_awlen;
    logic [2:0]        m_awsize;
    logic [1:0]        m_awburst;
    logic              m_wvalid, m_wready;
    logic [DW-1:0]     m_wdata;
    logic [SW-1:0]     m_wstrb;
    logic              m_wlast;
    logic              m_bvalid, m_bready;
    logic [IW-1:0]     m_bid;
    logic [1:0]        m_bresp;
    logic              busy;
    logic [1:0]        grant_idx;
`ifdef AXI_WR_ARB_TIMEOUT_EN
    logic              timeout_err;
`endif

    axi_wr_arbiter #(
        .NUM_MASTERS(NM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)
`ifdef AXI_WR_ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_awid(s_awid), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_awid(m_awid), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
        .busy(busy),
`ifdef AXI_WR_ARB_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .grant_idx(grant_idx)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          m;
        logic [15:0] addr;
        logic [7:0]  id;
        logic [7:0]  len;
        logic [31:0] base;
        logic [3:0]  strb;
        logic [1:0]  bresp;
        int          exp_grant;
    } txn_t;

    txn_t tbl [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_inputs();
        s_awvalid = '0; s_awaddr = '0; s_awid = '0; s_awlen = '0;
        s_awsize = '0; s_awburst = '0;
        s_wvalid = '0; s_wlast = '0; s_wdata = '0; s_wstrb = '0;
        s_bready = '0;
        m_awready = 1'b0; m_wready = 1'b0;
        m_bvalid = 1'b0; m_bid = '0; m_bresp = 2'b00;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        clear_inputs();
        tick();
        tick();
        areset = 1'b0;
    endtask

    task automatic set_aw(input int m, input logic [15:0] addr, input logic [7:0] id,
                          input logic [7:0] len);
        s_awvalid[m]          = 1'b1;
        s_awaddr[m*AW +: AW]  = addr;
        s_awid[m*IW +: IW]    = id;
        s_awlen[m*8 +: 8]     = len;
        s_awsize[m*3 +: 3]    = 3'd2;
        s_awburst[m*2 +: 2]   = 2'b01;
    endtask

    // Full transaction on one master with the slave always ready.
    task automatic run_txn(input txn_t t);
        logic [3:0] oh;
        oh = 4'b0001 << t.m;
        set_aw(t.m, t.addr, t.id, t.len);
        m_awready = 1'b1;
        m_wready  = 1'b1;
        #1;
        chk("idle_awvalid", {31'd0, m_awvalid}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("addr_grant", {30'd0, grant_idx}, t.exp_grant);
        chk("addr_awvalid", {31'd0, m_awvalid}, 32'd1);
        chk("addr_awaddr", {16'd0, m_awaddr}, {16'd0, t.addr});
        chk("addr_awid", {24'd0, m_awid}, {24'd0, t.id});
        chk("addr_awlen", {24'd0, m_awlen}, {24'd0, t.len});
        chk("addr_awsize_burst", {27'd0, m_awsize, m_awburst}, 32'b10_01);
        chk("addr_s_awready", {28'd0, s_awready}, {28'd0, oh});
        tick();
        s_awvalid[t.m] = 1'b0;
        for (int b = 0; b <= int'(t.len); b++) begin
            s_wvalid[t.m]        = 1'b1;
            s_wdata[t.m*DW +: DW] = t.base + 32'(b);
            s_wstrb[t.m*SW +: SW] = t.strb;
            s_wlast[t.m]         = (b == int'(t.len));
            #1;
            chk("data_wvalid", {31'd0, m_wvalid}, 32'd1);
            chk("data_wdata", m_wdata, t.base + 32'(b));
            chk("data_wstrb", {28'd0, m_wstrb}, {28'd0, t.strb});
            chk("data_wlast", {31'd0, m_wlast}, (b == int'(t.len)) ? 32'd1 : 32'd0);
            chk("data_s_wready", {28'd0, s_wready}, {28'd0, oh});
            chk("data_grant", {30'd0, grant_idx}, t.exp_grant);
            tick();
        end
        s_wvalid[t.m] = 1'b0;
        s_wlast[t.m]  = 1'b0;
        m_bvalid      = 1'b1;
        m_bid         = t.id;
        m_bresp       = t.bresp;
        s_bready[t.m] = 1'b1;
        #1;
        chk("resp_s_bvalid", {28'd0, s_bvalid}, {28'd0, oh});
        chk("resp_s_bid", {24'd0, s_bid}, {24'd0, t.id});
        chk("resp_s_bresp", {30'd0, s_bresp}, {30'd0, t.bresp});
        chk("resp_m_bready", {31'd0, m_bready}, 32'd1);
        chk("resp_busy", {31'd0, busy}, 32'd1);
        tick();
        m_bvalid      = 1'b0;
        s_bready[t.m] = 1'b0;
        #1;
        chk("post_busy", {31'd0, busy}, 32'd0);
        chk("post_s_bvalid", {28'd0, s_bvalid}, 32'd0);
        chk("post_grant_held", {30'd0, grant_idx}, t.exp_grant);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int beat;
        int hs;
        logic wr;
        int exp_rr [5];

        tbl[0] = '{2, 16'h1000, 8'h05, 8'd3, 32'h000000A0, 4'hF, 2'b00, 2};
        tbl[1] = '{0, 16'h2222, 8'h11, 8'd0, 32'h11110000, 4'h3, 2'b10, 0};
        tbl[2] = '{3, 16'hBEEF, 8'hFE, 8'd1, 32'hDEAD0000, 4'hC, 2'b01, 3};
        tbl[3] = '{3, 16'h0004, 8'h7A, 8'd2, 32'h00000030, 4'hF, 2'b11, 3};
        tbl[4] = '{1, 16'h4440, 8'h21, 8'd0, 32'h5A5A5A5A, 4'h1, 2'b00, 1};
        exp_rr = '{0, 1, 2, 3, 0};

        // ---- reset state
        areset = 1'b1;
        clear_inputs();
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_grant", {30'd0, grant_idx}, 32'd0);
        chk("rst_valids", {28'd0, m_awvalid, m_wvalid, m_bready, 1'b0}, 32'd0);
        chk("rst_s_ready", {24'd0, s_awready, s_wready}, 32'd0);
        chk("rst_s_bvalid", {28'd0, s_bvalid}, 32'd0);
        areset = 1'b0;

        // ---- table-driven complete transactions
        for (int i = 0; i < 5; i++) begin
            run_txn(tbl[i]);
        end

        // ---- round-robin with all masters requesting continuously
        do_reset();
        for (int m = 0; m < NM; m++) begin
            set_aw(m, 16'h0100 * 16'(m + 1), 8'(m), 8'd0);
            s_wdata[m*DW +: DW] = 32'(m);
            s_wstrb[m*SW +: SW] = 4'hF;
        end
        s_wvalid = 4'hF; s_wlast = 4'hF; s_bready = 4'hF;
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1;
        k = 0;
        for (int c = 0; c < 40 && k < 5; c++) begin
            #1;
            if (s_awready != 4'd0) begin
                chk("rr_s_awready", {28'd0, s_awready}, 32'd1 << exp_rr[k]);
                chk("rr_grant", {30'd0, grant_idx}, exp_rr[k]);
                chk("rr_awaddr", {16'd0, m_awaddr}, 32'h100 * (exp_rr[k] + 1));
                k++;
            end
            tick();
        end
        chk("rr_grant_count", k, 32'd5);

        // ---- backpressure: AW stalled 5 cycles, W ready toggling, len=7
        do_reset();
        set_aw(3, 16'h3000, 8'h33, 8'd7);
        s_wstrb[3*SW +: SW] = 4'hF;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp_awvalid_stall", {31'd0, m_awvalid}, 32'd1);
            chk("bp_awready_stall", {28'd0, s_awready}, 32'd0);
            tick();
        end
        m_awready = 1'b1;
        #1;
        chk("bp_awready_go", {28'd0, s_awready}, 32'h8);
        tick();
        s_awvalid[3] = 1'b0;
        beat = 0; hs = 0; wr = 1'b0;
        for (int c = 0; c < 40 && beat < 8; c++) begin
            s_wvalid[3]          = 1'b1;
            s_wdata[3*DW +: DW]  = 32'hC0 + 32'(beat);
            s_wlast[3]           = (beat == 7);
            m_wready             = wr;
            wr                   = ~wr;
            #1;
            chk("bp_s_wready", {28'd0, s_wready}, m_wready ? 32'h8 : 32'h0);
            if (m_wvalid && m_wready) begin
                chk("bp_wdata", m_wdata, 32'hC0 + 32'(beat));
                chk("bp_wlast", {31'd0, m_wlast}, (beat == 7) ? 32'd1 : 32'd0);
                hs++;
                beat++;
            end
            tick();
        end
        m_wready = 1'b1;
        #1;
        chk("bp_resp_no_wvalid", {31'd0, m_wvalid}, 32'd0);
        chk("bp_hs_count", hs, 32'd8);
        s_wvalid[3] = 1'b0;
        m_bvalid = 1'b1; m_bid = 8'h33; s_bready[3] = 1'b1;
        #1;
        chk("bp_s_bvalid", {28'd0, s_bvalid}, 32'h8);
        tick();
        clear_inputs();

        // ---- early W on master 1
        s_wvalid[1] = 1'b1; s_wlast[1] = 1'b1;
        s_wdata[1*DW +: DW] = 32'h55556666; s_wstrb[1*SW +: SW] = 4'hF;
        m_wready = 1'b1; m_awready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("ew_wready_pre", {28'd0, s_wready}, 32'd0);
            chk("ew_wvalid_pre", {31'd0, m_wvalid}, 32'd0);
            tick();
        end
        set_aw(1, 16'h1111, 8'h42, 8'd0);
        #1;
        chk("ew_wready_idle", {28'd0, s_wready}, 32'd0);
        tick();
        chk("ew_wready_addr", {28'd0, s_wready}, 32'd0);
        chk("ew_grant", {30'd0, grant_idx}, 32'd1);
        tick();
        s_awvalid[1] = 1'b0;
        #1;
        chk("ew_wready_data", {28'd0, s_wready}, 32'h2);
        chk("ew_wdata", m_wdata, 32'h55556666);
        chk("ew_wlast", {31'd0, m_wlast}, 32'd1);
        tick();
        s_wvalid[1] = 1'b0; s_wlast[1] = 1'b0;
        m_bvalid = 1'b1; m_bid = 8'h42; s_bready[1] = 1'b1;
        #1;
        chk("ew_s_bvalid", {28'd0, s_bvalid}, 32'h2);
        chk("ew_s_bid", {24'd0, s_bid}, 32'h42);
        tick();
        clear_inputs();

        // ---- reset during beat 2 of a len=3 burst on master 2
        m_awready = 1'b1; m_wready = 1'b1;
        set_aw(2, 16'h2000, 8'h09, 8'd3);
        s_wstrb[2*SW +: SW] = 4'hF;
        tick();
        tick();
        s_awvalid[2] = 1'b0;
        for (int b = 0; b < 3; b++) begin
            s_wvalid[2] = 1'b1;
            s_wdata[2*DW +: DW] = 32'hE0 + 32'(b);
            if (b < 2) tick();
        end
        #1;
        areset = 1'b1;
        #1;
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_grant", {30'd0, grant_idx}, 32'd0);
        chk("mr_m_valids", {29'd0, m_awvalid, m_wvalid, m_bready}, 32'd0);
        chk("mr_s_ready", {24'd0, s_awready, s_wready}, 32'd0);
        chk("mr_s_bvalid", {28'd0, s_bvalid}, 32'd0);
        clear_inputs();
        tick();
        areset = 1'b0;
        m_awready = 1'b1;
        set_aw(0, 16'h0A00, 8'h01, 8'd0);
        set_aw(2, 16'h2A00, 8'h02, 8'd0);
        tick();
        chk("mr_first_grant", {30'd0, grant_idx}, 32'd0);
        chk("mr_first_awready", {28'd0, s_awready}, 32'h1);

`ifdef AXI_WR_ARB_TIMEOUT_EN
        // ---- watchdog: B withheld 20 cycles in RESP
        do_reset();
        m_awready = 1'b1; m_wready = 1'b1;
        set_aw(1, 16'h7000, 8'h07, 8'd0);
        s_wvalid[1] = 1'b1; s_wlast[1] = 1'b1;
        tick();
        tick();
        s_awvalid[1] = 1'b0;
        tick();
        s_wvalid[1] = 1'b0; s_wlast[1] = 1'b0; s_bready[1] = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 15) chk("to_err_before", {31'd0, timeout_err}, 32'd0);
            if (c == 16) chk("to_err_at_16", {31'd0, timeout_err}, 32'd1);
        end
        m_bvalid = 1'b1;
        tick();
        m_bvalid = 1'b0;
        #1;
        chk("to_busy_done", {31'd0, busy}, 32'd0);
        chk("to_err_sticky", {31'd0, timeout_err}, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
